wb_commit: RTL and testbench

Write-back commit unit for the 5-stage MIPS pipeline. It sits between the EX/MEM result paths and the register file write port. It accepts up to two results per cycle: one from the ALU path and one from the load path. It serialises them through a small in-order queue into the single `we`/`wb_addr`/`wb_data` port the register file provides. It also answers a combinational forwarding query from ID, so decode sees values still in flight.

---
 rtl/wb_commit.sv | 172 +++++++++++++++++
 tb/tb_wb_commit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Write-back commit unit: merges ALU and load results into an in-order queue,
// drains one entry per cycle into the register-file write port, and answers
// ID forwarding queries against everything still in flight.
module wb_commit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        in_ready,
    output logic        we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data,
    output logic        ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_ptr_p1;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          ovf_q, ovf_d;

    logic          mem_push, alu_push, q_nonempty, drop_alu;
    logic          enq0_v, enq1_v;
    logic [4:0]    enq0_a, enq1_a;
    logic [31:0]   enq0_d, enq1_d;

    logic [DEPTH-1:0] slot_match;
    logic [31:0]      slot_data [DEPTH];

    // Writes to register 0 are architecturally meaningless, so they never enter.
    assign mem_push   = mem_valid && (mem_addr != 5'd0);
    assign alu_push   = alu_valid && (alu_addr != 5'd0);
    assign q_nonempty = (count_q != '0);
    // Only a dual push onto a full queue can overshoot by one; the younger ALU entry loses.
    assign drop_alu   = (count_q == CW'(DEPTH)) && mem_push && alu_push;
    assign wr_ptr_p1  = wr_ptr_q + PW'(1);

    // Choose the entry to commit (queue head, else oldest incoming) and what is left to enqueue.
    always_comb begin
        enq0_v    = 1'b0;
        enq1_v    = 1'b0;
        enq0_a    = mem_addr;
        enq0_d    = mem_data;
        enq1_a    = alu_addr;
        enq1_d    = alu_data;
        we_d      = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q | drop_alu;
        if (q_nonempty) begin
            we_d      = 1'b1;
            wb_addr_d = addr_mem[rd_ptr_q];
            wb_data_d = data_mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PW'(1);
            if (mem_push) begin
                enq0_v = 1'b1;
                enq1_v = alu_push && !drop_alu;
            end else if (alu_push) begin
                enq0_v = 1'b1;
                enq0_a = alu_addr;
                enq0_d = alu_data;
            end
        end else if (mem_push) begin
            // Empty queue: the load bypasses straight to the write port, the ALU result waits.
            we_d      = 1'b1;
            wb_addr_d = mem_addr;
            wb_data_d = mem_data;
            if (alu_push) begin
                enq0_v = 1'b1;
                enq0_a = alu_addr;
                enq0_d = alu_data;
            end
        end else if (alu_push) begin
            we_d      = 1'b1;
            wb_addr_d = alu_addr;
            wb_data_d = alu_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(enq0_v) + PW'(enq1_v);
        count_d  = count_q + CW'(enq0_v) + CW'(enq1_v) - CW'(q_nonempty);
    end

    // Queue storage; data needs no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (!rst && enq0_v) begin
            addr_mem[wr_ptr_q] <= enq0_a;
            data_mem[wr_ptr_q] <= enq0_d;
        end
        if (!rst && enq1_v) begin
            addr_mem[wr_ptr_p1] <= enq1_a;
            data_mem[wr_ptr_p1] <= enq1_d;
        end
    end

    // Control state and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Per-slot match, indexed by age (gi = 0 is the head, higher is newer).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] idx;
        assign idx             = rd_ptr_q + PW'(gi);
        assign slot_match[gi]  = (CW'(gi) < count_q) && (addr_mem[idx] == q_addr);
        assign slot_data[gi]   = data_mem[idx];
    end

    // Forwarding search: later assignments override, so sources are applied oldest first.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_addr != 5'd0) begin
            if (we_q && (wb_addr_q == q_addr)) begin
                q_hit  = 1'b1;
                q_data = wb_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_match[i]) begin
                    q_hit  = 1'b1;
                    q_data = slot_data[i];
                end
            end
            if (mem_valid && (mem_addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = mem_data;
            end
            if (alu_valid && (alu_addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = alu_data;
            end
        end
    end

    assign in_ready = (count_q < CW'(DEPTH));
    assign we       = we_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: a queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_commit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr, q_addr;
    logic [31:0] alu_data, mem_data;
    logic        in_ready, we, q_hit, ovf;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, q_data;

    int n_checks = 0;
    int n_fail   = 0;

    wb_commit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .in_ready(in_ready), .we(we), .wb_addr(wb_addr), .wb_data(wb_data),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic        m_ovf  = 1'b0;

    task automatic model_clear();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    // All pending results in age order; commit the oldest, drop the alu one on overshoot.
    task automatic model_step();
        ent_t lst[$];
        ent_t e;
        lst = mq;
        if (mem_valid && mem_addr != 5'd0) lst.push_back({mem_addr, mem_data});
        if (alu_valid && alu_addr != 5'd0) lst.push_back({alu_addr, alu_data});
        if (lst.size() > 0) begin
            e      = lst.pop_front();
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (lst.size() > DEPTH) begin
            void'(lst.pop_back());
            m_ovf = 1'b1;
        end
        mq = lst;
    endtask

    function automatic void model_query(output logic hit, output logic [31:0] dat);
        hit = 1'b0;
        dat = '0;
        if (q_addr == 5'd0) return;
        if (alu_valid && alu_addr == q_addr) begin hit = 1'b1; dat = alu_data; return; end
        if (mem_valid && mem_addr == q_addr) begin hit = 1'b1; dat = mem_data; return; end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == q_addr) begin hit = 1'b1; dat = mq[i].d; return; end
        end
        if (m_we && m_addr == q_addr) begin hit = 1'b1; dat = m_data; end
    endfunction

    // Compare process: combinational outputs mid-cycle, registered outputs after each edge.
    initial begin
        logic        e_hit;
        logic [31:0] e_dat;
        forever begin
            @(negedge clk); #3;
            if (rst) model_clear();
            model_query(e_hit, e_dat);
            check("m_in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
            check("m_q_hit", q_hit, e_hit);
            check("m_q_data", q_data, e_dat);
            check("m_we_mid", we, m_we);
            @(posedge clk); #1;
            if (rst) model_clear();
            else model_step();
            check("m_we", we, m_we);
            check("m_wb_addr", wb_addr, m_addr);
            check("m_wb_data", wb_data, m_data);
            check("m_ovf", ovf, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic [4:0] qa);
        @(negedge clk);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        q_addr    = qa;
        #2;
    endtask

    task automatic idle(input logic [4:0] qa);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
    endtask

    task automatic tick();
        @(posedge clk); #2;
        $display("[%0t] mem=%0b r%0d alu=%0b r%0d -> we=%0b r%0d 0x%0h ready=%0b ovf=%0b",
                 $time, mem_valid, mem_addr, alu_valid, alu_addr, we, wb_addr, wb_data,
                 in_ready, ovf);
    endtask

    initial begin
        int          nwe;
        logic [4:0]  last_addr;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        q_addr    = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_we", we, 0);
        check("rst_ready", in_ready, 1);
        check("rst_qhit", q_hit, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single push: commits on the next edge, then idles.
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd0);
        tick();
        check("single_we", we, 1);
        check("single_addr", wb_addr, 5);
        check("single_data", wb_data, 32'h1234);
        idle(5'd0);
        tick();
        check("single_we_off", we, 0);
        check("single_addr_hold", wb_addr, 5);

        // Dual push: load older than ALU.
        set_in(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd0);
        tick();
        check("dual_1_we", we, 1);
        check("dual_1_addr", wb_addr, 3);
        check("dual_1_data", wb_data, 32'hAAAA);
        idle(5'd0);
        tick();
        check("dual_2_we", we, 1);
        check("dual_2_addr", wb_addr, 4);
        check("dual_2_data", wb_data, 32'hBBBB);
        idle(5'd0);
        tick();
        check("dual_we_off", we, 0);

        // Register 0 is discarded and never hits.
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0);
        check("r0_qhit", q_hit, 0);
        tick();
        check("r0_we", we, 0);

        // Forwarding priority: incoming beats queue, queue beats output register.
        set_in(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h10, 5'd7);
        check("fwd_in_hit", q_hit, 1);
        check("fwd_in_data", q_data, 32'h10);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h20, 5'd7);
        check("fwd_new_hit", q_hit, 1);
        check("fwd_new_data", q_data, 32'h20);
        tick();
        check("fwd_commit_addr", wb_addr, 7);
        check("fwd_commit_data", wb_data, 32'h10);
        idle(5'd7);
        check("fwd_queue_hit", q_hit, 1);
        check("fwd_queue_data", q_data, 32'h20);
        tick();
        check("fwd_commit2_data", wb_data, 32'h20);
        idle(5'd7);
        check("fwd_outreg_data", q_data, 32'h20);
        tick();
        idle(5'd7);
        check("fwd_gone_hit", q_hit, 0);
        check("fwd_gone_data", q_data, 0);
        tick();

        // Back-pressure: four dual pushes fill the queue, the fifth overflows.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 5'(8 + 2 * k), 32'h100 + k, 1'b1, 5'(9 + 2 * k), 32'h200 + k, 5'd0);
            check("bp_ready", in_ready, 1);
            tick();
        end
        set_in(1'b1, 5'd16, 32'h104, 1'b1, 5'd17, 32'h204, 5'd0);
        check("bp_full", in_ready, 0);
        tick();
        check("bp_ovf", ovf, 1);
        nwe       = 0;
        last_addr = '0;
        for (int k = 0; k < 6; k++) begin
            idle(5'd0);
            tick();
            if (we) begin
                nwe++;
                last_addr = wb_addr;
            end
        end
        check("bp_drain_count", nwe, 4);
        check("bp_last_addr", last_addr, 16);
        check("bp_ovf_sticky", ovf, 1);

        // Reset with three entries queued.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 5'(20 + 2 * k), 32'h300 + k, 1'b1, 5'(21 + 2 * k), 32'h400 + k, 5'd25);
            tick();
        end
        @(negedge clk);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        rst       = 1'b1;
        #2;
        check("mrst_we", we, 0);
        check("mrst_ready", in_ready, 1);
        check("mrst_ovf", ovf, 0);
        check("mrst_qhit", q_hit, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(5'd25);
            tick();
            check("mrst_no_stale", we, 0);
            check("mrst_ready_after", in_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
